mem_stage: RTL

// MIPS MEM stage plus MEM/WB register, directly downstream of EX. Performs
// LB/LBU/LH/LHU/LW/SB/SH/SW over a req/ack data bus; other ops pass straight through.

---
 rtl/mem_stage_if.sv | 32 +++
 rtl/mem_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Data-bus bundle between the MEM stage (master) and the memory or bus fabric (slave).
// Handshake: the master raises bus_req_o with addr/sel/we/wdata stable and holds all of them
// until a cycle where bus_ack_i is high; that edge completes the transfer and rdata is taken then.
interface mem_stage_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  modport master (
    output bus_req_o,
    output bus_we_o,
    output bus_addr_o,
    output bus_sel_o,
    output bus_wdata_o,
    input  bus_rdata_i,
    input  bus_ack_i
  );

  modport slave (
    input  bus_req_o,
    input  bus_we_o,
    input  bus_addr_o,
    input  bus_sel_o,
    input  bus_wdata_o,
    output bus_rdata_i,
    output bus_ack_i
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage with MEM/WB register: big-endian byte/half/word loads and stores over a
// req/ack bus, alignment and timeout exceptions, and a stall request while an access is open.
module mem_stage #(
  parameter int TO_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [7:0]  aluop_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  mem_stage_if.master bus,
  output logic        stall_req_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        exc_o,
  output logic [1:0]  exc_code_o,
  output logic        dbg_state_o
);

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  localparam int CNT_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       op_q, op_d;
  logic [1:0]       off_q, off_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [3:0]       bus_sel_q, bus_sel_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [4:0]       wd_q, wd_d;
  logic             wreg_q, wreg_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             exc_q, exc_d;
  logic [1:0]       exc_code_q, exc_code_d;

  logic in_is_load, in_is_store, in_is_mem, in_misaligned;

  function automatic logic op_is_load(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic op_is_store(input logic [7:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] off);
    logic [3:0] sel;
    sel = 4'b1111;
    case (op)
      OP_LB, OP_LBU, OP_SB: sel = 4'b1000 >> off;
      OP_LH, OP_LHU, OP_SH: sel = off[1] ? 4'b0011 : 4'b1100;
      default:              sel = 4'b1111;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [7:0] op, input logic [31:0] d);
    logic [31:0] w;
    w = d;
    case (op)
      OP_SB:   w = {4{d[7:0]}};
      OP_SH:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Lane 0 (off==00) is bits 31:24: big-endian byte numbering within the word.
  function automatic logic [31:0] load_extract(input logic [7:0] op, input logic [1:0] off,
                                               input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    case (off)
      2'd0:    b = r[31:24];
      2'd1:    b = r[23:16];
      2'd2:    b = r[15:8];
      default: b = r[7:0];
    endcase
    h = off[1] ? r[15:0] : r[31:16];
    case (op)
      OP_LB:   v = {{24{b[7]}}, b};
      OP_LBU:  v = {24'h0, b};
      OP_LH:   v = {{16{h[15]}}, h};
      OP_LHU:  v = {16'h0, h};
      default: v = r;
    endcase
    return v;
  endfunction

  always_comb begin
    in_is_load    = op_is_load(aluop_i);
    in_is_store   = op_is_store(aluop_i);
    in_is_mem     = in_is_load || in_is_store;
    in_misaligned = 1'b0;
    case (aluop_i)
      OP_LH, OP_LHU, OP_SH: in_misaligned = mem_addr_i[0];
      OP_LW, OP_SW:         in_misaligned = |mem_addr_i[1:0];
      default:              in_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    off_d       = off_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    exc_d       = 1'b0;
    exc_code_d  = 2'b00;
    stall_req_o = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (valid_i && in_is_mem) begin
          wreg_d = 1'b0;
          if (in_misaligned) begin
            exc_d      = 1'b1;
            exc_code_d = in_is_load ? 2'b01 : 2'b10;
          end else begin
            stall_req_o = 1'b1;
            state_d     = BUSY;
            bus_req_d   = 1'b1;
            bus_we_d    = in_is_store;
            bus_addr_d  = {mem_addr_i[31:2], 2'b00};
            bus_sel_d   = lane_sel(aluop_i, mem_addr_i[1:0]);
            bus_wdata_d = store_lanes(aluop_i, mem_data_i);
            op_d        = aluop_i;
            off_d       = mem_addr_i[1:0];
          end
        end else begin
          wd_d    = wd_i;
          wreg_d  = wreg_i & valid_i;
          wdata_d = wdata_i;
        end
      end

      BUSY: begin
        wreg_d = 1'b0;
        cnt_d  = cnt_q + CNT_W'(1);
        // Ack is checked first so that an ack in the final timeout cycle still completes.
        if (bus.bus_ack_i) begin
          state_d   = IDLE;
          cnt_d     = '0;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          bus_sel_d = 4'b0000;
          if (op_is_load(op_q)) begin
            wd_d    = wd_i;
            wreg_d  = wreg_i;
            wdata_d = load_extract(op_q, off_q, bus.bus_rdata_i);
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          cnt_d      = '0;
          bus_req_d  = 1'b0;
          bus_we_d   = 1'b0;
          bus_sel_d  = 4'b0000;
          exc_d      = 1'b1;
          exc_code_d = 2'b11;
        end else begin
          stall_req_o = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      off_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      wdata_q     <= '0;
      exc_q       <= 1'b0;
      exc_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      off_q       <= off_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      exc_q       <= exc_d;
      exc_code_q  <= exc_code_d;
    end
  end

  assign bus.bus_req_o   = bus_req_q;
  assign bus.bus_we_o    = bus_we_q;
  assign bus.bus_addr_o  = bus_addr_q;
  assign bus.bus_sel_o   = bus_sel_q;
  assign bus.bus_wdata_o = bus_wdata_q;
  assign wd_o            = wd_q;
  assign wreg_o          = wreg_q;
  assign wdata_o         = wdata_q;
  assign exc_o           = exc_q;
  assign exc_code_o      = exc_code_q;
  assign dbg_state_o     = state_q;

endmodule
